// File: rtl/uart_tx.sv
// UART transmitter: start, DATA_BITS data bits (LSB first), STOP_BITS stop bits.
// Define UART_TX_PARITY_EN to insert an even-parity bit after the data bits.
module uart_tx #(
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 baud_tick,
  output logic                 baud_en,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 tx_busy
);

  localparam int CW = $clog2(DATA_BITS + 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_e;

  state_e                 state_q, state_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   stop_q, stop_d;
  logic                   tx_q, tx_d;
  logic                   ready_q, ready_d;
`ifdef UART_TX_PARITY_EN
  logic                   par_q, par_d;
`endif

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    stop_d  = stop_q;
    tx_d    = tx_q;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    unique case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (tx_valid && ready_q) begin
          shift_d = tx_data;
          cnt_d   = '0;
          stop_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
          par_d   = ^tx_data;
`endif
          state_d = START;
          tx_d    = 1'b0;
        end
      end
      START: begin
        if (baud_tick) begin
          state_d = DATA;
          tx_d    = shift_q[0];
        end
      end
      DATA: begin
        if (baud_tick) begin
          // tx shows the bit the shift register exposes next
          shift_d = shift_q >> 1;
          cnt_d   = cnt_q + CW'(1);
          if (cnt_q == CW'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
            tx_d    = par_q;
`else
            state_d = STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            tx_d = shift_q[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (baud_tick) begin
          state_d = STOP;
          tx_d    = 1'b1;
        end
      end
`endif
      STOP: begin
        tx_d = 1'b1;
        if (baud_tick) begin
          if (stop_q == 1'(STOP_BITS - 1)) begin
            state_d = IDLE;
          end else begin
            stop_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      stop_q  <= 1'b0;
      tx_q    <= 1'b1;
      ready_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      stop_q  <= stop_d;
      tx_q    <= tx_d;
      ready_q <= ready_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign tx       = tx_q;
  assign tx_ready = ready_q;
  assign tx_busy  = (state_q != IDLE);
  assign baud_en  = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: frame-level model compared every cycle, plus literal waveforms.
// u0 uses one stop bit, u1 two; both honour UART_TX_PARITY_EN.
module tb_uart_tx;

`ifdef UART_TX_PARITY_EN
  localparam int PB = 1;
  localparam logic [15:0] E_A5 = 16'h054A;
  localparam logic [15:0] E_00 = 16'h0C00;
  localparam logic [15:0] E_3C = 16'h0478;
  localparam logic [15:0] E_C3 = 16'h0586;
  localparam logic [15:0] E_55 = 16'h04AA;
`else
  localparam int PB = 0;
  localparam logic [15:0] E_A5 = 16'h034A;
  localparam logic [15:0] E_00 = 16'h0600;
  localparam logic [15:0] E_3C = 16'h0278;
  localparam logic [15:0] E_C3 = 16'h0386;
  localparam logic [15:0] E_55 = 16'h02AA;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] data [2] = '{8'h00, 8'h00};
  logic [1:0] vld  = 2'b00;
  logic [1:0] tick = 2'b00;
  wire  [1:0] txw, rdy, busy, ben;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int rec0[$];
  int rec1[$];

  always #5 clk = ~clk;

  uart_tx #(.DATA_BITS(8), .STOP_BITS(1)) u0 (
    .clk(clk), .rst(rst), .baud_tick(tick[0]), .baud_en(ben[0]),
    .tx_data(data[0]), .tx_valid(vld[0]), .tx_ready(rdy[0]),
    .tx(txw[0]), .tx_busy(busy[0])
  );

  uart_tx #(.DATA_BITS(8), .STOP_BITS(2)) u1 (
    .clk(clk), .rst(rst), .baud_tick(tick[1]), .baud_en(ben[1]),
    .tx_data(data[1]), .tx_valid(vld[1]), .tx_ready(rdy[1]),
    .tx(txw[1]), .tx_busy(busy[1])
  );

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Free-running baud divider: one tick every 4 clocks, also while idle
  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      tick = (cyc % 4 == 0) ? 2'b11 : 2'b00;
    end
  end

  // Frame model: list of line levels, one per baud period
  function automatic logic [15:0] frame(input logic [7:0] d);
    logic [15:0] f;
    f      = '1;
    f[0]   = 1'b0;
    f[8:1] = d;
`ifdef UART_TX_PARITY_EN
    f[9]   = ^d;
`endif
    return f;
  endfunction

  logic [15:0] fb   [2] = '{16'hFFFF, 16'hFFFF};
  int          flen [2] = '{0, 0};
  int          fpos [2] = '{0, 0};
  logic        inf  [2] = '{1'b0, 1'b0};
  logic        mrdy [2] = '{1'b0, 1'b0};

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        inf[k]  <= 1'b0;
        mrdy[k] <= 1'b0;
      end else if (!inf[k]) begin
        if (vld[k] && mrdy[k]) begin
          fb[k]   <= frame(data[k]);
          flen[k] <= 10 + PB + k;
          fpos[k] <= 0;
          inf[k]  <= 1'b1;
          mrdy[k] <= 1'b0;
        end else begin
          mrdy[k] <= 1'b1;
        end
      end else if (tick[k]) begin
        if (fpos[k] + 1 == flen[k]) begin
          inf[k]  <= 1'b0;
          mrdy[k] <= 1'b1;
        end
        fpos[k] <= fpos[k] + 1;
      end
    end
  end

  function automatic logic [3:0] exp_out(input int k);
    if (rst) return 4'b1000;
    return {inf[k] ? fb[k][fpos[k]] : 1'b1, inf[k], mrdy[k], inf[k]};
  endfunction

  // {tx, baud_en, tx_ready, tx_busy} against the model every cycle
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      chk(k == 0 ? "cycle u0" : "cycle u1",
          int'({txw[k], ben[k], rdy[k], busy[k]}), int'(exp_out(k)));
    end
    if (busy[0] && tick[0]) rec0.push_back(int'(txw[0]));
    if (busy[1] && tick[1]) rec1.push_back(int'(txw[1]));
  end

  task automatic chk_seq(input string nm, input int q[$],
                         input logic [15:0] e, input int len);
    logic [15:0] v;
    v = '0;
    chk({nm, " periods"}, q.size(), len);
    foreach (q[i]) if (i < 16) v[i] = (q[i] != 0);
    chk({nm, " wave"}, int'(v), int'(e));
  endtask

  task automatic wait_idle(input int k, input string nm, input bit scramble);
    int n;
    n = 0;
    while (busy[k] && n < 400) begin
      @(posedge clk);
      #1;
      if (scramble) data[k] = 8'($urandom);
      n++;
    end
    chk({nm, " done"}, int'(busy[k]), 0);
  endtask

  task automatic start_frame(input int k, input logic [7:0] d, input string nm);
    int n;
    data[k] = d;
    vld[k]  = 1'b1;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!busy[k] && n < 50);
    vld[k] = 1'b0;
    chk({nm, " accept"}, int'(busy[k]), 1);
  endtask

  initial begin
    int gap;
    int n;
    repeat (3) @(posedge clk);
    #1;
    chk("reset outs", int'({txw[0], ben[0], rdy[0], busy[0]}), 4'b1000);
    rst = 1'b0;
    @(negedge clk);
    chk("ready before edge", int'(rdy[0]), 0);
    @(posedge clk);
    #1;
    chk("ready after edge", int'(rdy[0]), 1);

    // ticks while idle must not start anything
    repeat (12) @(posedge clk);
    #1;
    chk("idle ticks", int'({txw[0], ben[0], busy[0], rdy[0]}), 4'b1001);

    rec0.delete();
    start_frame(0, 8'hA5, "a5");
    wait_idle(0, "a5", 1'b1);
    chk_seq("a5", rec0, E_A5, 10 + PB);
    chk("a5 end", int'({rdy[0], ben[0]}), 2'b10);

`ifdef UART_TX_PARITY_EN
    rec0.delete();
    start_frame(0, 8'h07, "07");
    wait_idle(0, "07", 1'b1);
    chk_seq("07", rec0, 16'h060E, 11);
`endif

    rec1.delete();
    start_frame(1, 8'h00, "00s2");
    wait_idle(1, "00s2", 1'b1);
    chk_seq("00s2", rec1, E_00, 11 + PB);

    // back-to-back with tx_valid held high
    rec0.delete();
    data[0] = 8'h3C;
    vld[0]  = 1'b1;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!busy[0] && n < 50);
    data[0] = 8'hC3;
    wait_idle(0, "3c", 1'b0);
    chk_seq("3c", rec0, E_3C, 10 + PB);
    rec0.delete();
    gap = 0;
    while (!busy[0] && gap < 10) begin
      gap++;
      @(posedge clk);
      #1;
    end
    vld[0] = 1'b0;
    chk("b2b gap", gap, 1);
    wait_idle(0, "c3", 1'b0);
    chk_seq("c3", rec0, E_C3, 10 + PB);

    // reset while bit 4 of 0xFF is on the line
    rec0.delete();
    start_frame(0, 8'hFF, "ff");
    n = 0;
    while (rec0.size() < 5 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("ff reached bit4", rec0.size(), 5);
    #2 rst = 1'b1;
    #1;
    chk("abort outs", int'({txw[0], ben[0], rdy[0], busy[0]}), 4'b1000);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort ready low", int'(rdy[0]), 0);
    @(posedge clk);
    #1;
    chk("abort ready high", int'({rdy[0], busy[0]}), 2'b10);

    rec0.delete();
    start_frame(0, 8'h55, "55");
    wait_idle(0, "55", 1'b1);
    chk_seq("55", rec0, E_55, 10 + PB);

    repeat (4) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
